keypad_timer_entry: RTL
=======================

KEYPAD_TIMER_ENTRY -- requirements
Module: keypad_timer_entry

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4, the number of consecutive stable samples required to accept a button level.
REQ-002 The block SHALL have parameter TMAX, default 99, the saturation ceiling for timer in seconds.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset, asynchronous and active-high.
REQ-005 The block SHALL have port btn_add10_raw, input, 1 bit, an asynchronous raw "+10 s" key.
REQ-006 The block SHALL have port btn_add1_raw, input, 1 bit, an asynchronous raw "+1 s" key.
REQ-007 The block SHALL have port btn_power_raw, input, 1 bit, an asynchronous raw power-level toggle key.
REQ-008 The block SHALL have port btn_start_raw, input, 1 bit, an asynchronous raw start key.
REQ-009 The block SHALL have port btn_cancel_raw, input, 1 bit, an asynchronous raw cancel key.
REQ-010 The block SHALL have port cook_done, input, 1 bit, a single-cycle pulse from the downstream controller when cooking finishes.
REQ-011 The block SHALL have port timer, output, 7 bits, the registered entered cook time in seconds, range 0..TMAX.
REQ-012 The block SHALL have port power, output, 1 bit, the registered power level (0 = HALF, 1 = FULL).
REQ-013 The block SHALL have port start_button, output, 1 bit, a single-cycle registered start pulse to the controller.
REQ-014 The block SHALL have port cancel_button, output, 1 bit, a single-cycle registered cancel pulse to the controller.
REQ-015 The block SHALL have port locked, output, 1 bit, which is high while edits are inhibited.

Function
REQ-016 The block SHALL pass each raw key through a 2-flop synchronizer and a debouncer, and SHALL accept a new level only after DB_CYCLES identical consecutive synchronized samples.
REQ-017 The block SHALL produce one internal key pulse per debounced rising edge, so a held key yields exactly one pulse and a released key yields none.
REQ-018 The latency from a stable raw press to its internal pulse SHALL be 2 + DB_CYCLES cycles, and the registered outputs SHALL update one cycle after that pulse.
REQ-019 The FSM SHALL have two states: EDIT (locked=0) and LOCKED (locked=1).
REQ-020 In EDIT, the add10 pulse SHALL set timer to min(timer+10, TMAX) and the add1 pulse SHALL set timer to min(timer+1, TMAX).
REQ-021 In EDIT, simultaneous add10 and add1 pulses SHALL set timer to min(timer+11, TMAX).
REQ-022 The block SHALL compute sums 8 bits wide before saturation, so no wrap-around is possible.
REQ-023 In EDIT, the power pulse SHALL toggle power.
REQ-024 In EDIT, a start pulse with timer != 0 SHALL assert start_button for exactly one cycle and move the FSM to LOCKED, with timer and power held.
REQ-025 In EDIT, a start pulse with timer == 0 SHALL be ignored unless QUICK_START_EN is defined (see REQ-033).
REQ-026 In LOCKED, add10, add1, power and start pulses SHALL be ignored.
REQ-027 A cancel pulse in either state SHALL assert cancel_button for one cycle, clear timer to 0, leave power unchanged, and move the FSM to EDIT.
REQ-028 A cancel pulse SHALL take priority over every other pulse in the same cycle.
REQ-029 A cook_done pulse in LOCKED SHALL clear timer to 0 and move the FSM to EDIT, and a cook_done pulse in EDIT SHALL be ignored.
REQ-030 If cook_done and cancel occur in the same cycle, the cancel behaviour SHALL apply, with cancel_button asserted.

Reset
REQ-031 While rst is high, regardless of clk, the block SHALL force the FSM to EDIT, timer=0, power=0, start_button=0, cancel_button=0, locked=0, all synchronizer flops to 0 and all debounce counters to 0.
REQ-032 A key held across reset release SHALL be treated as a fresh press, producing one pulse after the full synchronize-and-debounce latency.

Configuration
REQ-033 When macro QUICK_START_EN is defined, a start pulse in EDIT with timer == 0 SHALL load timer=30 and assert start_button in the same cycle, and the FSM SHALL enter LOCKED.
REQ-034 When QUICK_START_EN is undefined, that case SHALL produce no output change.

Structure
REQ-035 Package keypad_pkg SHALL hold the FSM state typedef (EDIT, LOCKED), the constant QUICK_START_SECS = 30, and the constants ADD10 = 10 and ADD1 = 1.
REQ-036 Sub-module key_debounce (parameter DB_CYCLES; ports clk, rst, raw, level, rise_pulse) SHALL be instantiated five times.

Verification
REQ-037 The bench SHALL check: reset, then press add10 ten times -> timer=99 (saturated), and one further add1 -> timer stays 99.
REQ-038 The bench SHALL check: a raw start glitch high for 2 cycles with DB_CYCLES=4 -> no start_button pulse and timer unchanged.
REQ-039 The bench SHALL check: timer=45, start held 50 cycles -> exactly one start_button pulse, locked=1, and a subsequent add1 leaves timer at 45.
REQ-040 The bench SHALL check: in LOCKED, cook_done pulse -> timer=0 and locked=0, and a following power press toggles power 0->1.
REQ-041 The bench SHALL check: cancel and add10 pulses in the same cycle with timer=20 -> timer=0, cancel_button pulses once, and timer is not 30.
REQ-042 The bench SHALL check: start with timer=0 -> timer=30 and start_button pulses when built with QUICK_START_EN, and no output change when built without it.

Source files
------------

// File: rtl/keypad_timer_entry_pkg.sv
// Shared types and constants for the keypad timer entry block.
// Consumed by the top; QUICK_START_SECS only matters with QUICK_START_EN.
package keypad_pkg;

  typedef enum logic {
    EDIT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int QUICK_START_SECS = 30;
  localparam int ADD10 = 10;
  localparam int ADD1  = 1;

  // Sum is 8 bits wide so timer + 11 can never wrap.
  function automatic logic [6:0] sat_add(
    input logic [6:0] t,
    input logic [7:0] inc,
    input logic [7:0] tmax
  );
    logic [7:0] s;
    s = {1'b0, t} + inc;
    return (s > tmax) ? tmax[6:0] : s[6:0];
  endfunction

endpackage

// File: rtl/keypad_timer_entry_if.sv
// Controller-facing bundle of the keypad timer entry block.
// master = keypad side, slave = downstream cook controller.
interface keypad_timer_entry_if;

  logic [6:0] timer;
  logic       power;
  logic       start_button;
  logic       cancel_button;
  logic       locked;
  logic       cook_done;

  modport master (
    output timer,
    output power,
    output start_button,
    output cancel_button,
    output locked,
    input  cook_done
  );

  modport slave (
    input  timer,
    input  power,
    input  start_button,
    input  cancel_button,
    input  locked,
    output cook_done
  );

endinterface

// File: rtl/keypad_timer_entry_key_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw key.
// rise_pulse fires once, in the cycle the debounced level goes high.
module key_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      s1         <= raw;
      s2         <= s1;
      rise_pulse <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt        <= '0;
        level      <= s2;
        rise_pulse <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_timer_entry.sv
// Keypad cook-time entry: debounced keys drive an EDIT/LOCKED FSM.
// Define QUICK_START_EN to make start at timer==0 load 30 s and lock.
module keypad_timer_entry
  import keypad_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int TMAX      = 99
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_add10_raw,
  input  logic btn_add1_raw,
  input  logic btn_power_raw,
  input  logic btn_start_raw,
  input  logic btn_cancel_raw,
  keypad_timer_entry_if.master ctl
);

  localparam logic [7:0] TMAX8 = 8'(TMAX);

`ifdef QUICK_START_EN
  localparam bit QUICK = 1'b1;
`else
  localparam bit QUICK = 1'b0;
`endif

  logic [4:0] raw_keys;
  logic [4:0] key_lvl;
  logic [4:0] key_rise;
  logic [4:0] key_evt;

  assign raw_keys = {btn_cancel_raw, btn_start_raw,
                     btn_power_raw, btn_add1_raw,
                     btn_add10_raw};

  for (genvar i = 0; i < 5; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .raw       (raw_keys[i]),
      .level     (key_lvl[i]),
      .rise_pulse(key_rise[i])
    );
  end

  // A rise is only honoured while the debounced level agrees.
  assign key_evt = key_rise & key_lvl;

  logic k_add10;
  logic k_add1;
  logic k_power;
  logic k_start;
  logic k_cancel;

  assign k_add10  = key_evt[0];
  assign k_add1   = key_evt[1];
  assign k_power  = key_evt[2];
  assign k_start  = key_evt[3];
  assign k_cancel = key_evt[4];

  logic [7:0] inc;

  always_comb begin
    inc = 8'd0;
    if (k_add10) inc = inc + 8'(ADD10);
    if (k_add1)  inc = inc + 8'(ADD1);
  end

  state_t     state;
  logic [6:0] timer_q;
  logic       power_q;
  logic       start_q;
  logic       cancel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EDIT;
      timer_q  <= '0;
      power_q  <= 1'b0;
      start_q  <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      cancel_q <= 1'b0;
      if (k_cancel) begin
        cancel_q <= 1'b1;
        timer_q  <= '0;
        state    <= EDIT;
      end else if (state == LOCKED) begin
        if (ctl.cook_done) begin
          timer_q <= '0;
          state   <= EDIT;
        end
      end else if (k_start &&
                   (timer_q != '0 || QUICK)) begin
        if (timer_q == '0)
          timer_q <= 7'(QUICK_START_SECS);
        start_q <= 1'b1;
        state   <= LOCKED;
      end else begin
        timer_q <= sat_add(timer_q, inc, TMAX8);
        if (k_power)
          power_q <= ~power_q;
      end
    end
  end

  assign ctl.timer         = timer_q;
  assign ctl.power         = power_q;
  assign ctl.start_button  = start_q;
  assign ctl.cancel_button = cancel_q;
  assign ctl.locked        = (state == LOCKED);

endmodule
